// File: rtl/qspi_arb.sv
// qspi_arb: grant/done arbiter and sequencer sharing the QSPI line engine between icache and dcache.
// Optional `QSPI_ARB_FAIR_EN: bounds how many data grants may pass a waiting ifetch.
module qspi_arb #(
  parameter int unsigned PA          = 24,
  parameter int unsigned LINE_LENGTH = 4,
  parameter int unsigned STARVE      = 4,
  localparam int unsigned TW         = PA - $clog2(LINE_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [TW-1:0] i_tag,
  input  logic [1:0]    i_mem,
  output logic          i_gnt,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_write,
  input  logic [TW-1:0] d_tag,
  input  logic [1:0]    d_mem,
  output logic          d_gnt,
  output logic          d_done,
  output logic          q_req,
  output logic          q_i_d,
  output logic          q_write,
  output logic [TW-1:0] q_paddr,
  output logic [1:0]    q_mem,
  input  logic          q_done,
  output logic          busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] GAP    = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_d;
  logic [TW-1:0] q_paddr_d;
  logic [1:0]    q_mem_d;
  logic          q_write_d;
  logic          i_wins;

  if (STARVE == 0) begin : g_bad_starve
    $error("qspi_arb: STARVE must be at least 1");
  end

`ifdef QSPI_ARB_FAIR_EN
  localparam int unsigned CW = $clog2(STARVE + 1);
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_cnt_d;

  // A starved ifetch beats a simultaneous data request once the budget is spent.
  assign i_wins = i_req && (starve_cnt == CW'(STARVE));
`else
  assign i_wins = 1'b0;
`endif

  // Done is echoed in the same cycle as q_done, qualified by the owning state.
  assign i_done = q_done && (state == BUSY_I);
  assign d_done = q_done && (state == BUSY_D);

  always_comb begin
    state_d   = state;
    q_paddr_d = q_paddr;
    q_mem_d   = q_mem;
    q_write_d = 1'b0;
`ifdef QSPI_ARB_FAIR_EN
    starve_cnt_d = starve_cnt;
`endif
    case (state)
      BUSY_I, BUSY_D: begin
        if (q_done) state_d = GAP;
        else        q_write_d = q_write;
      end
      // IDLE, and the edge closing GAP, so a waiting request follows after a single dead cycle.
      default: begin
        state_d = IDLE;
        if (d_req && !i_wins) begin
          state_d   = BUSY_D;
          q_paddr_d = d_tag;
          q_mem_d   = d_mem;
          q_write_d = d_write;
`ifdef QSPI_ARB_FAIR_EN
          if (i_req && (starve_cnt != CW'(STARVE))) starve_cnt_d = starve_cnt + CW'(1);
`endif
        end else if (i_req) begin
          state_d   = BUSY_I;
          q_paddr_d = i_tag;
          q_mem_d   = i_mem;
`ifdef QSPI_ARB_FAIR_EN
          starve_cnt_d = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      i_gnt   <= 1'b0;
      d_gnt   <= 1'b0;
      q_req   <= 1'b0;
      q_i_d   <= 1'b0;
      q_write <= 1'b0;
      q_paddr <= '0;
      q_mem   <= 2'd0;
      busy    <= 1'b0;
`ifdef QSPI_ARB_FAIR_EN
      starve_cnt <= '0;
`endif
    end else begin
      state   <= state_d;
      i_gnt   <= (state_d == BUSY_I);
      d_gnt   <= (state_d == BUSY_D);
      q_req   <= (state_d == BUSY_I) || (state_d == BUSY_D);
      q_i_d   <= (state_d == BUSY_I);
      q_write <= q_write_d;
      q_paddr <= q_paddr_d;
      q_mem   <= q_mem_d;
      busy    <= (state_d != IDLE);
`ifdef QSPI_ARB_FAIR_EN
      starve_cnt <= starve_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_qspi_arb.sv
// tb_qspi_arb: scoreboard bench for qspi_arb; expected grants are queued by the stimulus and
// popped by a monitor when q_req rises, with a fixed-latency qspi model answering each request.
`timescale 1ns/1ps
module tb_qspi_arb;
  localparam int unsigned PA          = 24;
  localparam int unsigned LINE_LENGTH = 4;
  localparam int unsigned STARVE      = 4;
  localparam int unsigned TW          = PA - $clog2(LINE_LENGTH);
  localparam int unsigned LAT         = 4;
`ifdef QSPI_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  typedef struct {
    bit            is_i;
    bit            write;
    logic [TW-1:0] tag;
    logic [1:0]    mem;
    bit            b2b;
  } xfer_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [TW-1:0] i_tag = '0;
  logic [1:0]    i_mem = 2'd0;
  logic          i_gnt, i_done;
  logic          d_req = 1'b0;
  logic          d_write = 1'b0;
  logic [TW-1:0] d_tag = '0;
  logic [1:0]    d_mem = 2'd0;
  logic          d_gnt, d_done;
  logic          q_req, q_i_d, q_write, busy;
  logic [TW-1:0] q_paddr;
  logic [1:0]    q_mem;
  logic          q_done;
  logic          model_done = 1'b0;
  logic          spur_done = 1'b0;
  int unsigned   qcnt = 0;

  xfer_t exp_q[$];
  xfer_t cur;
  int    n_checks = 0;
  int    n_fail = 0;
  bit    in_xfer = 1'b0;
  bit    prev_q = 1'b0;
  bit    gap_pending = 1'b0;
  int    cyc = 0;
  int    done_cyc = 0;

  assign q_done = model_done | spur_done;

  qspi_arb #(.PA(PA), .LINE_LENGTH(LINE_LENGTH), .STARVE(STARVE)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_tag(i_tag), .i_mem(i_mem), .i_gnt(i_gnt), .i_done(i_done),
    .d_req(d_req), .d_write(d_write), .d_tag(d_tag), .d_mem(d_mem), .d_gnt(d_gnt), .d_done(d_done),
    .q_req(q_req), .q_i_d(q_i_d), .q_write(q_write), .q_paddr(q_paddr), .q_mem(q_mem),
    .q_done(q_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Engine model: q_done pulses LAT cycles after the request is first seen.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      qcnt       <= 0;
      model_done <= 1'b0;
    end else if (model_done) begin
      model_done <= 1'b0;
      qcnt       <= 0;
    end else if (q_req) begin
      if (qcnt == LAT - 1) model_done <= 1'b1;
      else                 qcnt <= qcnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input bit is_i, input bit wr, input logic [TW-1:0] tag,
                               input logic [1:0] mem, input bit b2b);
    xfer_t x;
    x.is_i = is_i; x.write = wr; x.tag = tag; x.mem = mem; x.b2b = b2b;
    exp_q.push_back(x);
  endfunction

  // side: 0 = d_done, 1 = i_done, 2 = either
  task automatic wait_done(input int side, input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      seen = (side == 1) ? i_done : (side == 0) ? d_done : (i_done | d_done);
    end
    if (!seen) chk({name, "_timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (reset) begin
          in_xfer = 1'b0; prev_q = 1'b0; gap_pending = 1'b0;
        end else begin
          if (gap_pending) begin
            chk("gap_idle", 32'({q_req, i_gnt, d_gnt}), 32'd0);
            chk("gap_busy", 32'(busy), 32'd1);
            gap_pending = 1'b0;
          end
          if (q_req && !prev_q) begin
            if (exp_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL unexpected_grant: got i_gnt=%0b d_gnt=%0b, expected no grant", i_gnt, d_gnt);
            end else begin
              cur = exp_q.pop_front();
              in_xfer = 1'b1;
              chk("gnt_side", 32'({i_gnt, d_gnt}), cur.is_i ? 32'd2 : 32'd1);
              chk("q_i_d", 32'(q_i_d), 32'(cur.is_i));
              chk("q_write", 32'(q_write), 32'(cur.write));
              chk("q_paddr", 32'(q_paddr), 32'(cur.tag));
              chk("q_mem", 32'(q_mem), 32'(cur.mem));
              chk("busy", 32'(busy), 32'd1);
              if (cur.b2b) chk("b2b_spacing", 32'(cyc - done_cyc), 32'd2);
            end
          end
          if (q_done) begin
            if (in_xfer) begin
              chk("done_pulse", 32'({i_done, d_done}), cur.is_i ? 32'd2 : 32'd1);
              chk("hold_paddr", 32'(q_paddr), 32'(cur.tag));
              chk("hold_ctl", 32'({q_req, q_write, q_mem}), 32'({1'b1, cur.write, cur.mem}));
              in_xfer = 1'b0; gap_pending = 1'b1; done_cyc = cyc;
            end else begin
              chk("spurious_done", 32'({i_done, d_done, q_req}), 32'd0);
            end
          end
          prev_q = q_req;
        end
      end
    join_none

    // reset state
    #1 reset = 1'b1;
    #2;
    chk("rst_ctl", 32'({i_gnt, d_gnt, q_req, q_i_d, q_write, busy, i_done, d_done}), 32'd0);
    chk("rst_addr", 32'({q_paddr, q_mem}), 32'd0);
    @(posedge clk); step();
    reset = 1'b0;
    step();

    // single ifetch
    i_tag = TW'(22'h12345); i_mem = 2'd2; i_req = 1'b1;
    push(1'b1, 1'b0, TW'(22'h12345), 2'd2, 1'b0);
    chk("gnt_pre_edge", 32'(i_gnt), 32'd0);
    step();
    chk("gnt_latency", 32'({i_gnt, q_req}), 32'd3);
    wait_done(1, "single_i");
    step(); i_req = 1'b0;
    step();

    // simultaneous: data write-back wins, ifetch follows after one gap cycle
    d_write = 1'b1; d_tag = TW'(22'h00abc); d_mem = 2'd1; d_req = 1'b1;
    i_tag = TW'(22'h2aaaa); i_mem = 2'd3; i_req = 1'b1;
    push(1'b0, 1'b1, TW'(22'h00abc), 2'd1, 1'b0);
    push(1'b1, 1'b0, TW'(22'h2aaaa), 2'd3, 1'b1);
    wait_done(0, "simul_d");
    step(); d_req = 1'b0;
    wait_done(1, "simul_i");
    step(); i_req = 1'b0;
    step();

    // back-to-back data write-back then fill
    d_write = 1'b1; d_tag = TW'(22'h3c0de); d_mem = 2'd2; d_req = 1'b1;
    push(1'b0, 1'b1, TW'(22'h3c0de), 2'd2, 1'b0);
    wait_done(0, "b2b_wb");
    step(); d_write = 1'b0; d_tag = TW'(22'h01f00); d_mem = 2'd0;
    push(1'b0, 1'b0, TW'(22'h01f00), 2'd0, 1'b1);
    wait_done(0, "b2b_fill");
    step(); d_req = 1'b0;
    step();

    // tag stability while busy, then a spurious q_done in idle
    i_tag = TW'(22'h155aa); i_mem = 2'd1; i_req = 1'b1;
    push(1'b1, 1'b0, TW'(22'h155aa), 2'd1, 1'b0);
    step();
    repeat (2) begin i_tag = ~i_tag; step(); end
    chk("stable_paddr", 32'(q_paddr), 32'h155aa);
    wait_done(1, "stable_i");
    step(); i_req = 1'b0;
    step();
    spur_done = 1'b1;
    step(); spur_done = 1'b0;
    chk("spurious_state", 32'({busy, q_req, i_gnt, d_gnt}), 32'd0);

    // asynchronous reset in the middle of a data transfer
    d_write = 1'b1; d_tag = TW'(22'h2f0f0); d_mem = 2'd3; d_req = 1'b1;
    push(1'b0, 1'b1, TW'(22'h2f0f0), 2'd3, 1'b0);
    step();
    chk("d_gnt_on", 32'({d_gnt, busy}), 32'd3);
    step();
    reset = 1'b1;
    #1;
    chk("abort_ctl", 32'({i_gnt, d_gnt, q_req, q_i_d, q_write, busy, i_done, d_done}), 32'd0);
    chk("abort_addr", 32'({q_paddr, q_mem}), 32'd0);
    d_req = 1'b0; d_write = 1'b0;
    step(); reset = 1'b0;
    step();
    chk("after_abort", 32'({busy, q_req}), 32'd0);

    // starvation: both requests held for ten grants
    i_tag = TW'(22'h0a5a5); i_mem = 2'd2;
    d_tag = TW'(22'h0beef); d_mem = 2'd1; d_write = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (FAIR && (k % 5 == 4)) push(1'b1, 1'b0, TW'(22'h0a5a5), 2'd2, k != 0);
      else                      push(1'b0, 1'b0, TW'(22'h0beef), 2'd1, k != 0);
    end
    push(1'b1, 1'b0, TW'(22'h0a5a5), 2'd2, 1'b1);
    i_req = 1'b1; d_req = 1'b1;
    repeat (10) wait_done(2, "starve");
    step(); d_req = 1'b0;
    wait_done(1, "starve_last_i");
    step(); i_req = 1'b0;
    repeat (3) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
